// File: rtl/pipeline_hazard_ctrl.sv
// In-order pipeline hazard controller: a per-slot destination scoreboard that drives
// forwarding selects, load-use stalls, redirect flushes and saturating event counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned LOAD_AVAIL = 3,
   parameter int unsigned CNT_W      = 32,
   localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic              id_reg_write,
   input  logic              id_is_load,
   input  logic              ex_redirect,
   output logic              stall_fd,
   output logic              flush_fd,
   output logic              ex_valid,
   output logic [SEL_W-1:0]  fwd_sel_rs1,
   output logic [SEL_W-1:0]  fwd_sel_rs2,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   localparam int unsigned IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   // Scoreboard, bit/element k-1 holds slot k (slot 1 = execute)
   logic [DEPTH-1:0]             vld_q, vld_d;
   logic [DEPTH-1:0]             wr_q, wr_d;
   logic [DEPTH-1:0]             ld_q, ld_d;
   logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;

   logic [SEL_W-1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;
   logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;

   logic [1:0][REG_AW-1:0] src_addr;
   logic [1:0]             src_req;
   logic [1:0]             src_stall;
   logic [1:0][SEL_W-1:0]  src_sel;
   logic                   adv;

   // Youngest-match search: descending scan so the smallest slot index wins
   always_comb begin
      src_addr  = {id_rs2_addr, id_rs1_addr};
      src_req   = {id_valid && id_rs2_used && (id_rs2_addr != '0),
                   id_valid && id_rs1_used && (id_rs1_addr != '0)};
      src_stall = '0;
      src_sel   = '0;
      for (int unsigned s = 0; s < 2; s++) begin
         for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
            if (src_req[1'(s)] && vld_q[IDX_W'(k - 1)] && wr_q[IDX_W'(k - 1)] &&
                (rd_q[IDX_W'(k - 1)] == src_addr[1'(s)])) begin
               src_sel[1'(s)]   = SEL_W'(k + 1);
               src_stall[1'(s)] = ld_q[IDX_W'(k - 1)] && ((k + 1) < LOAD_AVAIL);
            end
         end
      end
   end

   assign flush_fd = ex_redirect;
   assign stall_fd = (|src_stall) && !ex_redirect;
   assign adv      = !stall_fd && !flush_fd && id_valid;

   // Slot shift: slot 1 takes decode or a bubble, older slots always advance
   always_comb begin
      vld_d = {vld_q[DEPTH-2:0], adv};
      wr_d  = {wr_q[DEPTH-2:0], adv && id_reg_write};
      ld_d  = {ld_q[DEPTH-2:0], adv && id_is_load};
      rd_d  = {rd_q[DEPTH-2:0], adv ? id_rd_addr : REG_AW'(0)};
      fwd1_d = adv ? src_sel[0] : '0;
      fwd2_d = adv ? src_sel[1] : '0;
      scnt_d = scnt_q;
      fcnt_d = fcnt_q;
      if (stall_fd && (scnt_q != '1)) scnt_d = scnt_q + CNT_W'(1);
      if (flush_fd && (fcnt_q != '1)) fcnt_d = fcnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         wr_q   <= '0;
         ld_q   <= '0;
         rd_q   <= '0;
         fwd1_q <= '0;
         fwd2_q <= '0;
         scnt_q <= '0;
         fcnt_q <= '0;
      end else begin
         vld_q  <= vld_d;
         wr_q   <= wr_d;
         ld_q   <= ld_d;
         rd_q   <= rd_d;
         fwd1_q <= fwd1_d;
         fwd2_q <= fwd2_d;
         scnt_q <= scnt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign ex_valid    = vld_q[0];
   assign fwd_sel_rs1 = fwd1_q;
   assign fwd_sel_rs2 = fwd2_q;
   assign stall_count = scnt_q;
   assign flush_count = fcnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: default-parameter instance (a_*) and a DEPTH=5/LOAD_AVAIL=4/CNT_W=4 instance (b_*).
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       a_valid, a_u1, a_u2, a_wr, a_ld, a_redir;
   logic [4:0] a_rs1, a_rs2, a_rd;
   logic       a_stall, a_flush, a_exv;
   logic [1:0] a_fwd1, a_fwd2;
   logic [31:0] a_scnt, a_fcnt;

   logic       b_valid, b_u1, b_u2, b_wr, b_ld, b_redir;
   logic [4:0] b_rs1, b_rs2, b_rd;
   logic       b_stall, b_flush, b_exv;
   logic [2:0] b_fwd1, b_fwd2;
   logic [3:0] b_scnt, b_fcnt;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_ctrl u_a (
      .clk(clk), .rst_n(rst_n), .id_valid(a_valid),
      .id_rs1_addr(a_rs1), .id_rs2_addr(a_rs2), .id_rs1_used(a_u1), .id_rs2_used(a_u2),
      .id_rd_addr(a_rd), .id_reg_write(a_wr), .id_is_load(a_ld), .ex_redirect(a_redir),
      .stall_fd(a_stall), .flush_fd(a_flush), .ex_valid(a_exv),
      .fwd_sel_rs1(a_fwd1), .fwd_sel_rs2(a_fwd2), .stall_count(a_scnt), .flush_count(a_fcnt)
   );

   pipeline_hazard_ctrl #(.REG_AW(5), .DEPTH(5), .LOAD_AVAIL(4), .CNT_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .id_valid(b_valid),
      .id_rs1_addr(b_rs1), .id_rs2_addr(b_rs2), .id_rs1_used(b_u1), .id_rs2_used(b_u2),
      .id_rd_addr(b_rd), .id_reg_write(b_wr), .id_is_load(b_ld), .ex_redirect(b_redir),
      .stall_fd(b_stall), .flush_fd(b_flush), .ex_valid(b_exv),
      .fwd_sel_rs1(b_fwd1), .fwd_sel_rs2(b_fwd2), .stall_count(b_scnt), .flush_count(b_fcnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic a_drv(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic rdr);
      a_valid = v; a_rs1 = r1; a_u1 = u1; a_rs2 = r2; a_u2 = u2;
      a_rd = rd; a_wr = wr; a_ld = ld; a_redir = rdr;
   endtask

   task automatic b_drv(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic rdr);
      b_valid = v; b_rs1 = r1; b_u1 = u1; b_rs2 = r2; b_u2 = u2;
      b_rd = rd; b_wr = wr; b_ld = ld; b_redir = rdr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_stall", a_stall, 0);
      chk("rst_flush_follows", a_flush, 1);
      chk("rst_exv", a_exv, 0);
      chk("rst_fwd1", a_fwd1, 0);
      chk("rst_fwd2", a_fwd2, 0);
      chk("rst_scnt", a_scnt, 0);
      chk("rst_fcnt", a_fcnt, 0);
      chk("rst_b_exv", b_exv, 0);
      a_redir = 1'b0;
      #1;
      chk("rst_flush_low", a_flush, 0);
      @(negedge clk) rst_n = 1'b1;

      // ALU writer x5 then immediate consumer: forward from slot 2
      tick(); a_drv(1, 0, 0, 0, 0, 5, 1, 0, 0); #1;
      chk("alu_wr_stall", a_stall, 0);
      tick(); a_drv(1, 5, 1, 0, 0, 6, 1, 0, 0); #1;
      chk("alu_use_stall", a_stall, 0);
      tick(); a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("alu_fwd1", a_fwd1, 2);
      chk("alu_fwd2", a_fwd2, 0);
      chk("alu_exv", a_exv, 1);
      tick(); #1;
      chk("bubble_fwd1", a_fwd1, 0);
      chk("bubble_exv", a_exv, 0);

      // Load x7 then rs2 consumer: one stall, then forward from slot 3
      tick(); a_drv(1, 0, 0, 0, 0, 7, 1, 1, 0); #1;
      chk("ld7_stall", a_stall, 0);
      tick(); a_drv(1, 0, 0, 7, 1, 8, 1, 0, 0); #1;
      chk("ld7_use_stall", a_stall, 1);
      tick(); #1;
      chk("ld7_stall_done", a_stall, 0);
      chk("ld7_bubble_exv", a_exv, 0);
      tick(); a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("ld7_fwd2", a_fwd2, 3);
      chk("ld7_exv", a_exv, 1);
      chk("ld7_scnt", a_scnt, 1);

      // Load to x0 then reader of x0: no hazard
      tick(); a_drv(1, 0, 0, 0, 0, 0, 1, 1, 0); #1;
      tick(); a_drv(1, 0, 1, 0, 1, 13, 1, 0, 0); #1;
      chk("x0_stall", a_stall, 0);
      tick(); a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("x0_fwd1", a_fwd1, 0);
      chk("x0_fwd2", a_fwd2, 0);
      chk("x0_exv", a_exv, 1);

      // Load x10 then rs1 consumer
      tick(); a_drv(1, 0, 0, 0, 0, 10, 1, 1, 0); #1;
      tick(); a_drv(1, 10, 1, 0, 0, 14, 1, 0, 0); #1;
      chk("ld10_stall", a_stall, 1);
      tick(); #1;
      chk("ld10_stall_done", a_stall, 0);
      tick(); a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("ld10_fwd1", a_fwd1, 3);
      chk("ld10_scnt", a_scnt, 2);

      // Redirect coinciding with load-use hazard: flush wins
      tick(); a_drv(1, 0, 0, 0, 0, 9, 1, 1, 0); #1;
      tick(); a_drv(1, 9, 1, 0, 0, 15, 1, 0, 1); #1;
      chk("redir_flush", a_flush, 1);
      chk("redir_stall", a_stall, 0);
      tick(); a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("redir_exv", a_exv, 0);
      chk("redir_fcnt", a_fcnt, 1);
      chk("redir_scnt", a_scnt, 2);
      chk("redir_fwd1", a_fwd1, 0);

      // Reset asserted mid-stall
      tick(); a_drv(1, 0, 0, 0, 0, 11, 1, 1, 0); #1;
      tick(); a_drv(1, 0, 0, 11, 1, 16, 1, 0, 0); #1;
      chk("midrst_pre_stall", a_stall, 1);
      rst_n = 1'b0; #1;
      chk("midrst_stall", a_stall, 0);
      chk("midrst_exv", a_exv, 0);
      chk("midrst_scnt", a_scnt, 0);
      chk("midrst_fcnt", a_fcnt, 0);
      a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) rst_n = 1'b1;

      // DEPTH=5, LOAD_AVAIL=4: load x3 then consumer stalls twice
      tick(); b_drv(1, 0, 0, 0, 0, 3, 1, 1, 0); #1;
      chk("b_ld_stall", b_stall, 0);
      tick(); b_drv(1, 3, 1, 0, 0, 12, 1, 0, 0); #1;
      chk("b_use_stall1", b_stall, 1);
      tick(); #1;
      chk("b_use_stall2", b_stall, 1);
      chk("b_use_exv", b_exv, 0);
      tick(); #1;
      chk("b_use_stall3", b_stall, 0);
      tick(); b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("b_fwd1", b_fwd1, 4);
      chk("b_exv", b_exv, 1);
      chk("b_scnt", b_scnt, 2);

      // Two writers of x3 back to back: youngest (slot 1) wins
      tick(); b_drv(1, 0, 0, 0, 0, 3, 1, 0, 0); #1;
      tick(); b_drv(1, 0, 0, 0, 0, 3, 1, 0, 0); #1;
      tick(); b_drv(1, 0, 0, 3, 1, 12, 1, 0, 0); #1;
      chk("b_young_stall", b_stall, 0);
      tick(); b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("b_young_fwd2", b_fwd2, 2);

      // Self-dependent load chain keeps stalling: counter must saturate at 15
      tick(); b_drv(1, 3, 1, 0, 0, 3, 1, 1, 0); #1;
      repeat (40) tick();
      chk("b_sat_scnt", b_scnt, 15);
      for (int i = 0; i < 8 && !b_stall; i++) tick();
      chk("b_sat_stall_seen", b_stall, 1);
      rst_n = 1'b0; #1;
      chk("b_rst_stall", b_stall, 0);
      chk("b_rst_exv", b_exv, 0);
      chk("b_rst_scnt", b_scnt, 0);
      chk("b_rst_fwd1", b_fwd1, 0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("b_post_rst_stall", b_stall, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3: tracked post-decode slots, slot 1 = execute, slot DEPTH = writeback; legal range 2..7.
REQ-003 SHALL have parameter LOAD_AVAIL, default 3: first slot forwarding a load result; legal range 2..DEPTH.
REQ-004 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-005 SHALL define SEL_W = clog2(DEPTH+1).
REQ-006 SHALL have ports:
 clk  input  1  clock, rising edge
 rst_n  input  1  asynchronous active-low reset
 id_valid  input  1  decode holds a valid instruction
 id_rs1_addr, id_rs2_addr  input  REG_AW  decode source addresses
 id_rs1_used, id_rs2_used  input  1  source actually read
 id_rd_addr  input  REG_AW  decode destination
 id_reg_write, id_is_load  input  1  decode writes rd / is a load
 ex_redirect  input  1  taken branch/jump resolved in execute
 stall_fd  output  1  hold PC and fetch/decode register
 flush_fd  output  1  invalidate fetch/decode register
 ex_valid  output  1  slot 1 holds a real instruction
 fwd_sel_rs1, fwd_sel_rs2  output  SEL_W  execute operand source: 0 = register file, k = slot k result
 stall_count, flush_count  output  CNT_W  saturating event counters

Function
REQ-007 SHALL keep scoreboard slots 1..DEPTH, each {valid, rd, wr, load}, advancing every cycle; slot k+1 <= slot k.
REQ-008 Slot 1 SHALL load {id_valid, id_rd_addr, id_reg_write, id_is_load} when neither stall_fd nor flush_fd is asserted, otherwise a bubble (valid=0).
REQ-009 Hazard search per decode source SHALL apply only when id_valid, srcN_used, and address nonzero.
REQ-010 Search SHALL find the smallest k in 1..DEPTH-1 with slot k valid, wr, rd equal to the source; slot DEPTH is ignored (register file write-through).
REQ-011 If the match is a load and k+1 < LOAD_AVAIL, stall_fd SHALL assert combinationally in that cycle.
REQ-012 Otherwise the next fwd_sel for that source SHALL be k+1; with no match, 0.
REQ-013 fwd_sel_rs1/rs2 SHALL be registered, presented the cycle the instruction occupies slot 1 (one-cycle latency from decode).
REQ-014 fwd_sel SHALL register 0 whenever slot 1 receives a bubble.
REQ-015 flush_fd SHALL equal ex_redirect (combinational); on flush, the slot-1 load is a bubble and stall_fd SHALL be forced 0 (flush has priority).
REQ-016 Slots 2..DEPTH SHALL never be killed by stall or flush.
REQ-017 ex_valid SHALL equal slot 1 valid.
REQ-018 stall_count SHALL increment once per cycle with stall_fd=1, flush_count once per cycle with flush_fd=1; both saturate at all-ones.
REQ-019 A consumer of a load in slot 1 SHALL stall exactly LOAD_AVAIL-2 cycles, then forward from slot LOAD_AVAIL.
REQ-020 rs1 and rs2 SHALL be searched independently; either source may cause the stall.

Reset
REQ-021 rst_n low SHALL asynchronously clear all slots, fwd_sel_rs1/rs2, stall_count, flush_count to 0.
REQ-022 During and after reset with no input activity, stall_fd=0, flush_fd follows ex_redirect, ex_valid=0.
REQ-023 Reset asserted mid-stall SHALL drop stall_fd in the same cycle; no pending stall survives reset.

Verification
REQ-024 ALU x5 writer then consumer reading x5 next cycle (defaults) -> no stall, fwd_sel_rs1=2 while consumer in execute.
REQ-025 Load to x7 then consumer of x7 in rs2 immediately -> stall_fd=1 for exactly 1 cycle, ex_valid=0 for 1 cycle, then fwd_sel_rs2=3, stall_count=1.
REQ-026 Writer of x0 then reader of x0 -> fwd_sel=0, no stall.
REQ-027 ex_redirect=1 coinciding with load-use hazard -> flush_fd=1, stall_fd=0, next ex_valid=0, flush_count=1, stall_count unchanged.
REQ-028 DEPTH=5, LOAD_AVAIL=4, load to x3 then consumer -> 2 stall cycles, then fwd_sel=4; two writers to x3 in slots 1 and 2 -> fwd_sel=2 (youngest wins).
REQ-029 stall_count preset near all-ones with CNT_W=4, 20 stall cycles -> holds 15; rst_n pulse mid-sequence -> all outputs 0 immediately.
